cmp_seq_ctrl: RTL and testbench
===============================

Name: cmp_seq_ctrl

Overview:
- Multi-cycle sequencer that wraps the ALU compare/count datapath behind a start/done handshake.
- SLT/SLTU/SLTI/SLTIU complete in a single compute cycle.
- CLO/CLZ are computed iteratively, scanning BITS_PER_CYCLE bits per cycle from bit 31 downward. This removes the unbounded combinational loop from the ALU path.
- Sits between the ALU decode stage and the register-file write-back mux.

Parameters:
- BITS_PER_CYCLE, 4, bits examined per SCAN cycle. Legal values: 1, 2, 4, 8, 16, 32.
- NUM_CHUNKS, 32/BITS_PER_CYCLE, derived; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- instToDo  input  3  op code: 0 SLT, 1 SLTU, 2 SLTI, 3 SLTIU, 4 CLO, 5 CLZ; 6 and 7 are illegal.
- A  input  32  operand A; latched on accept.
- B  input  32  operand B; latched on accept; ignored for CLO/CLZ.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  32  registered result.
- err  output  1  high together with done when the op was illegal.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset:
  - state=IDLE, busy=0, done=0, err=0, result=0, internal counter and index cleared.
  - Reset mid-SCAN aborts the operation with no done pulse.
  - Reset has priority over start.
- States: IDLE, SCAN, DONE.
- Transitions:
  - IDLE, start=0 -> IDLE.
  - IDLE, start=1, op 0-3 -> DONE. result is written on that same edge:
    - ops 0 and 2: 1 if $signed(A)<$signed(B), else 0.
    - ops 1 and 3: 1 if A<B (unsigned), else 0.
  - IDLE, start=1, op 4/5 -> SCAN.
    - Latch A and target bit t: 1 for CLO, 0 for CLZ.
    - count=0, chunk index=NUM_CHUNKS-1.
  - IDLE, start=1, op 6/7 -> DONE with result=0 and err=1.
  - SCAN, each cycle, on the current chunk:
    - m = number of leading bits (MSB-first within the chunk) equal to t.
    - count += m.
    - If m<BITS_PER_CYCLE or chunk index==0 -> DONE, result=count (final). Otherwise decrement chunk index and stay in SCAN.
  - DONE -> IDLE unconditionally. done=1 and busy=1 during DONE.
- start handling:
  - start while busy is ignored; it is not queued.
  - start in the DONE cycle is ignored; the next op can be accepted in the following IDLE cycle.
- Latency, with the accept edge = k:
  - Compare/illegal ops: done high in the cycle after k.
  - CLO/CLZ: S = min(floor(c/BITS_PER_CYCLE)+1, NUM_CHUNKS) SCAN cycles, where c is the final count. done is high in cycle k+S+1.
- Boundaries:
  - CLO of 0xFFFFFFFF = 32; CLZ of 0x00000000 = 32. Both take NUM_CHUNKS SCAN cycles.
  - Count saturates at 32 and never wraps.
- Outputs:
  - result is held stable from DONE until the next accepted start.
  - err is cleared in the cycle after DONE.
  - Operand changes after accept have no effect.
- Widths:
  - count is 6 bits internally, zero-extended to 32.
  - Signed compare uses $signed on the latched operands only.

Decomposition:
- Shared package / header cmp_defs:
  - Op encodings OP_SLT=3'd0 … OP_CLZ=3'd5.
  - State encodings ST_IDLE, ST_SCAN, ST_DONE.
  - Constant DATA_W=32.
- One sub-module, lead_match_chunk:
  - Combinational.
  - Inputs: BITS_PER_CYCLE-bit chunk and target bit.
  - Output: m (leading-match count, 0..BITS_PER_CYCLE).
  - Instantiated once; the chunk is selected by index from the latched A.

Test Plan:
- Reset, then start with op=0, A=0xFFFFFFFF (-1), B=1 -> done at k+1, result=1, err=0. Repeat with op=1 (unsigned) -> result=0.
- op=5 (CLZ), A=0x00010000, BITS_PER_CYCLE=4 -> 4 SCAN cycles, done at k+5, result=15.
- op=4 (CLO), A=0xFFFFFFFF -> 8 SCAN cycles, done at k+9, result=32. Also op=5, A=0 -> result=32.
- op=4, A=0x7FFFFFFF -> 1 SCAN cycle, done at k+2, result=0.
- Back-to-back behaviour:
  - start held high continuously: second op accepted only in the IDLE cycle after DONE.
  - A changed during SCAN: result unaffected.
- Illegal and reset cases:
  - op=6 -> done at k+1 with err=1, result=0.
  - Assert reset during SCAN -> next cycle busy=0, no done pulse, result=0.

Source files
------------

// File: rtl/cmp_seq_ctrl_pkg.sv
// Shared definitions for the compare/count sequencer: data width, op codes
// and sequencer state encoding.
package cmp_seq_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [2:0] OP_SLT   = 3'd0;
    localparam logic [2:0] OP_SLTU  = 3'd1;
    localparam logic [2:0] OP_SLTI  = 3'd2;
    localparam logic [2:0] OP_SLTIU = 3'd3;
    localparam logic [2:0] OP_CLO   = 3'd4;
    localparam logic [2:0] OP_CLZ   = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lead_match_chunk.sv
// Counts how many leading bits (MSB first) of one chunk equal the target bit.
module lead_match_chunk #(
    parameter  int BITS_PER_CYCLE = 4,
    localparam int M_W            = $clog2(BITS_PER_CYCLE + 1)
) (
    input  logic [BITS_PER_CYCLE-1:0] chunk,
    input  logic                      target,
    output logic [M_W-1:0]            m
);

    logic run;

    // Walk from the MSB and stop counting at the first bit that differs.
    always_comb begin
        m   = '0;
        run = 1'b1;
        for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
            if (run && (chunk[i] == target)) begin
                m = m + M_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Start/done sequencer around the set-less-than compares and an iterative
// leading-ones/zeros counter that scans BITS_PER_CYCLE bits per cycle.
module cmp_seq_ctrl
    import cmp_seq_ctrl_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        instToDo,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              err
);

    localparam int NUM_CHUNKS = DATA_W / BITS_PER_CYCLE;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int M_W        = $clog2(BITS_PER_CYCLE + 1);

    state_t                    state;
    logic [DATA_W-1:0]         a_lat;
    logic                      tgt;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_next;
    logic [IDX_W-1:0]          idx;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [M_W-1:0]            m;
    logic                      last_chunk;

    // The running count can never legitimately exceed the word width.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W:0] sum);
        return (sum > (CNT_W+1)'(DATA_W)) ? CNT_W'(DATA_W) : sum[CNT_W-1:0];
    endfunction

    assign chunk      = a_lat[int'(idx) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign count_next = sat_count({1'b0, count} + (CNT_W+1)'(m));
    assign last_chunk = (32'(m) < BITS_PER_CYCLE) || (idx == '0);

    lead_match_chunk #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_match (
        .chunk (chunk),
        .target(tgt),
        .m     (m)
    );

    // Capture the scan operand and target bit when a request is accepted.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            a_lat <= A;
            tgt   <= (instToDo == OP_CLO);
        end
    end

    // Sequencer: single-cycle compares, iterative count, one-cycle done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            count  <= '0;
            idx    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        case (instToDo)
                            OP_SLT, OP_SLTI: begin
                                result <= {31'b0, ($signed(A) < $signed(B))};
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_SLTU, OP_SLTIU: begin
                                result <= {31'b0, (A < B)};
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                            OP_CLO, OP_CLZ: begin
                                count <= '0;
                                idx   <= IDX_W'(NUM_CHUNKS - 1);
                                state <= ST_SCAN;
                            end
                            default: begin
                                result <= '0;
                                err    <= 1'b1;
                                done   <= 1'b1;
                                state  <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_SCAN: begin
                    count <= count_next;
                    if (last_chunk) begin
                        result <= DATA_W'(count_next);
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Bench for cmp_seq_ctrl: directed and random ops against a behavioural model.
module tb_cmp_seq_ctrl;

    localparam int BPC = 4;
    localparam int NC  = 32 / BPC;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  instToDo = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    int tests = 0;
    int fails = 0;

    cmp_seq_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .instToDo(instToDo),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .err     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: result, err and cycles from accept edge to done.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic e, output int lat);
        int   c;
        int   s;
        logic t;
        res = '0;
        e   = 1'b0;
        lat = 1;
        case (op)
            3'd0, 3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd1, 3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4, 3'd5: begin
                t = (op == 3'd4);
                c = 0;
                for (int i = 31; i >= 0; i--) begin
                    if (a[i] !== t) break;
                    c++;
                end
                res = 32'(c);
                s   = c / BPC + 1;
                if (s > NC) s = NC;
                lat = s + 1;
            end
            default: e = 1'b1;
        endcase
    endfunction

    // Issues one op from IDLE and observes done timing plus the following cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output logic e,
                          output logic [31:0] res_after, output logic e_after,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        start = 1'b1; instToDo = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        lat = 1;
        while (!done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        res = result;
        e   = err;
        @(negedge clk);
        res_after  = result;
        e_after    = err;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; instToDo = 3'd4; A = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_compare();
        logic [2:0]  op;
        logic [31:0] a, b, res, ra, er;
        logic        e, ea, da, ba, ee;
        int          lat, el;
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      begin op = 3'd0; a = 32'hFFFF_FFFF; b = 32'd1; end
            else if (i == 1) begin op = 3'd1; a = 32'hFFFF_FFFF; b = 32'd1; end
            else begin
                op = 3'($urandom_range(0, 3));
                a  = $urandom;
                b  = (i % 4 == 0) ? a : $urandom;
            end
            model(op, a, b, er, ee, el);
            if (i == 0) er = 32'd1;
            if (i == 1) er = 32'd0;
            run_op(op, a, b, lat, res, e, ra, ea, da, ba);
            tests++; if (lat !== el) begin fails++; $display("FAIL cmp_latency op=%0d got %0d want %0d", op, lat, el); end
            tests++; if (res !== er) begin fails++; $display("FAIL cmp_result op=%0d a=%h b=%h got %h want %h", op, a, b, res, er); end
            tests++; if (e !== 1'b0) begin fails++; $display("FAIL cmp_err op=%0d got %b want 0", op, e); end
            tests++; if (ra !== er) begin fails++; $display("FAIL cmp_hold op=%0d got %h want %h", op, ra, er); end
            tests++; if ({da, ba} !== 2'b00) begin fails++; $display("FAIL cmp_after done/busy got %b%b want 00", da, ba); end
        end
    endtask

    task automatic test_count();
        logic [2:0]  op;
        logic [31:0] a, res, ra, er;
        logic        e, ea, da, ba, ee;
        int          lat, el, sh;
        for (int i = 0; i < 22; i++) begin
            case (i)
                0: begin op = 3'd5; a = 32'h0001_0000; end
                1: begin op = 3'd4; a = 32'hFFFF_FFFF; end
                2: begin op = 3'd5; a = 32'h0000_0000; end
                3: begin op = 3'd4; a = 32'h7FFF_FFFF; end
                default: begin
                    op = 3'($urandom_range(4, 5));
                    sh = $urandom_range(0, 32);
                    a  = (sh == 32) ? 32'd0 : (($urandom | 32'h8000_0000) >> sh);
                    if (op == 3'd4) a = ~a;
                end
            endcase
            model(op, a, 32'd0, er, ee, el);
            case (i)
                0: begin er = 32'd15; el = 5; end
                1: begin er = 32'd32; el = 9; end
                2: begin er = 32'd32; el = 9; end
                3: begin er = 32'd0;  el = 2; end
                default: ;
            endcase
            run_op(op, a, $urandom, lat, res, e, ra, ea, da, ba);
            tests++; if (lat !== el) begin fails++; $display("FAIL cnt_latency op=%0d a=%h got %0d want %0d", op, a, lat, el); end
            tests++; if (res !== er) begin fails++; $display("FAIL cnt_result op=%0d a=%h got %0d want %0d", op, a, res, er); end
            tests++; if (e !== 1'b0) begin fails++; $display("FAIL cnt_err op=%0d got %b want 0", op, e); end
            tests++; if (ra !== er) begin fails++; $display("FAIL cnt_hold op=%0d got %0d want %0d", op, ra, er); end
            tests++; if ({da, ba} !== 2'b00) begin fails++; $display("FAIL cnt_after done/busy got %b%b want 00", da, ba); end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] res, ra;
        logic        e, ea, da, ba;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_op(3'(6 + (i % 2)), $urandom, $urandom, lat, res, e, ra, ea, da, ba);
            tests++; if (lat !== 1) begin fails++; $display("FAIL ill_latency got %0d want 1", lat); end
            tests++; if (res !== 32'd0) begin fails++; $display("FAIL ill_result got %h want 0", res); end
            tests++; if (e !== 1'b1) begin fails++; $display("FAIL ill_err got %b want 1", e); end
            tests++; if (ea !== 1'b0) begin fails++; $display("FAIL ill_err_clear got %b want 0", ea); end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        // Compare with start held: second op only taken after the idle cycle.
        @(negedge clk);
        start = 1'b1; instToDo = 3'd0; A = 32'd3; B = 32'd7;
        @(negedge clk);
        tests++; if ({done, result} !== {1'b1, 32'd1}) begin fails++; $display("FAIL b2b_first done=%b result=%h want 1/1", done, result); end
        A = 32'd9; B = 32'd2;
        @(negedge clk);
        tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL b2b_gap busy/done got %b%b want 00", busy, done); end
        @(negedge clk);
        tests++; if ({done, result} !== {1'b1, 32'd0}) begin fails++; $display("FAIL b2b_second done=%b result=%h want 1/0", done, result); end
        start = 1'b0;
        @(negedge clk);
        // Count with start held and operands scrambled during SCAN.
        start = 1'b1; instToDo = 3'd5; A = 32'h0001_0000;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 64) begin
            A = $urandom | 32'h8000_0000; instToDo = 3'd0;
            @(negedge clk);
            lat++;
        end
        tests++; if (lat !== 5) begin fails++; $display("FAIL b2b_scan_latency got %0d want 5", lat); end
        tests++; if (result !== 32'd15) begin fails++; $display("FAIL b2b_scan_result got %0d want 15", result); end
        instToDo = 3'd1; A = 32'd5; B = 32'd9;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_scan_gap busy got %b want 0", busy); end
        @(negedge clk);
        tests++; if ({done, result} !== {1'b1, 32'd1}) begin fails++; $display("FAIL b2b_after_scan done=%b result=%h want 1/1", done, result); end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int pulses;
        @(negedge clk);
        start = 1'b1; instToDo = 3'd4; A = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_scan_busy_before got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL rst_scan_flags got %b want 000", {busy, done, err}); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL rst_scan_result got %h want 0", result); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        tests++; if (pulses !== 0) begin fails++; $display("FAIL rst_scan_no_done got %0d active cycles want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_compare();
        test_count();
        test_illegal();
        test_back_to_back();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
